// File: rtl/fifo_drain_if.sv
// Handshake bundle between fifo_drain, its upstream FIFO and the downstream consumer.
// The master side is the drain block itself; the slave side is the environment around it.
interface fifo_drain_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  words_sent;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_pop, out_valid, out_data, words_sent, busy
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_pop, out_valid, out_data, words_sent, busy
  );
endinterface

// File: rtl/fifo_drain.sv
// Drains an upstream zero-latency FIFO through a 2-entry skid buffer into a
// valid/ready stream, counting delivered words with a saturating counter.
module fifo_drain #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  fifo_drain_if.master  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              push;
  logic              hs;

  assign push = bus.fifo_pop;
  assign hs   = bus.out_valid && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the buffer entries are reset as well, because out_data must read 0
      // after reset; larger storage arrays are normally left unreset.
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = bus.fifo_data;
          state_d = ONE;
        end
      end
      ONE: begin
        // A push and a handshake on the same edge replace the head in place.
        if (push && hs) begin
          head_d = bus.fifo_data;
        end else if (push) begin
          tail_d  = bus.fifo_data;
          state_d = FULL;
        end else if (hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (hs) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    sent_d = sent_q;
    if (hs && (sent_q != {CNT_W{1'b1}})) begin
      sent_d = sent_q + CNT_W'(1);
    end
  end

  // Pop is blocked at FULL even when the consumer is ready, keeping out_ready
  // off the path to fifo_pop.
  always_comb begin
    bus.out_valid = (state_q != EMPTY);
    bus.fifo_pop  = !reset && !bus.fifo_empty && (state_q != FULL);
    bus.busy      = (state_q != EMPTY) || !bus.fifo_empty;
  end

  assign bus.out_data   = head_q;
  assign bus.words_sent = sent_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the drain behaviour.
module tb_fifo_drain;

  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_drain_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  fifo_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Reference model: words held inside the block, oldest first, and total handshakes.
  logic [DW-1:0] mq[$];
  int            msent = 0;

  // Applies the effect of the rising edge that just happened, using the inputs
  // that were stable across it.
  function automatic void model_edge();
    bit hs;
    bit push;
    if (reset) begin
      mq.delete();
      msent = 0;
      return;
    end
    hs   = (mq.size() > 0) && bus.out_ready;
    push = !bus.fifo_empty && (mq.size() < 2);
    if (hs) begin
      void'(mq.pop_front());
      msent++;
    end
    if (push) mq.push_back(bus.fifo_data);
  endfunction

  function automatic logic exp_pop();
    return !reset && !bus.fifo_empty && (mq.size() < 2);
  endfunction

  function automatic logic [CW-1:0] exp_sent();
    return (msent > SAT) ? CW'(SAT) : CW'(msent);
  endfunction

  task automatic drive(input logic rst, input logic fe, input logic [DW-1:0] fd, input logic rdy);
    @(negedge clk);
    model_edge();
    reset          = rst;
    bus.fifo_empty = fe;
    bus.fifo_data  = fd;
    bus.out_ready  = rdy;
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b1, 1'b1, '0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    checks++;
    if (bus.fifo_pop !== 1'b0) begin
      errors++; $display("FAIL reset_pop: got %b expected 0", bus.fifo_pop);
    end
    drive(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", bus.out_data);
    end
    checks++;
    if (bus.words_sent !== '0) begin
      errors++; $display("FAIL reset_sent: got %0d expected 0", bus.words_sent);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single();
    reset_dut();
    drive(1'b0, 1'b0, 32'hA5A5_0001, 1'b1);
    checks++;
    if (bus.fifo_pop !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop: got pop=%b valid=%b expected pop=1 valid=0", bus.fifo_pop, bus.out_valid);
    end
    drive(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5_0001 || bus.fifo_pop !== 1'b0) begin
      errors++; $display("FAIL single_out: got valid=%b data=%h pop=%b expected 1 a5a50001 0", bus.out_valid, bus.out_data, bus.fifo_pop);
    end
    drive(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (bus.words_sent !== CW'(1) || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got sent=%0d valid=%b busy=%b expected 1 0 0", bus.words_sent, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] want [4];
    logic          pop_want [4];
    reset_dut();
    drive(1'b0, 1'b0, 32'h11, 1'b0);
    drive(1'b0, 1'b0, 32'h22, 1'b0);
    // FULL with out_ready low, then high: pop must stay low in both cycles.
    want     = '{32'h11, 32'h11, 32'h22, 32'h33};
    pop_want = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i == 3), 32'h33, (i > 0));
      checks++;
      if (bus.fifo_pop !== pop_want[i] || bus.out_valid !== 1'b1 || bus.out_data !== want[i]) begin
        errors++; $display("FAIL backpressure_%0d: got pop=%b valid=%b data=%h expected pop=%b valid=1 data=%h",
                           i, bus.fifo_pop, bus.out_valid, bus.out_data, pop_want[i], want[i]);
      end
    end
    drive(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (bus.words_sent !== CW'(3) || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_done: got sent=%0d valid=%b expected 3 0", bus.words_sent, bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i >= 8), DW'(i + 1), 1'b1);
      checks++;
      if (bus.fifo_pop !== (i < 8) || bus.out_valid !== (i >= 1 && i <= 8) ||
          ((i >= 1 && i <= 8) && bus.out_data !== DW'(i))) begin
        errors++; $display("FAIL stream_%0d: got pop=%b valid=%b data=%h expected pop=%b valid=%b data=%h",
                           i, bus.fifo_pop, bus.out_valid, bus.out_data, (i < 8), (i >= 1 && i <= 8), i);
      end
    end
    checks++;
    if (bus.words_sent !== CW'(8)) begin
      errors++; $display("FAIL stream_count: got %0d expected 8", bus.words_sent);
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    drive(1'b0, 1'b0, 32'h40, 1'b0);
    drive(1'b0, 1'b0, 32'h44, 1'b1);
    checks++;
    if (bus.fifo_pop !== 1'b1 || bus.out_data !== 32'h40) begin
      errors++; $display("FAIL simul_pre: got pop=%b data=%h expected 1 40", bus.fifo_pop, bus.out_data);
    end
    // Still ONE afterwards: a further pop must be allowed and the head is the new word.
    drive(1'b0, 1'b0, 32'h55, 1'b0);
    checks++;
    if (bus.fifo_pop !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'h44) begin
      errors++; $display("FAIL simul_post: got pop=%b valid=%b data=%h expected 1 1 44", bus.fifo_pop, bus.out_valid, bus.out_data);
    end
    drive(1'b0, 1'b1, '0, 1'b1);
    drive(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (bus.out_data !== 32'h55 || bus.words_sent !== CW'(2)) begin
      errors++; $display("FAIL simul_drain: got data=%h sent=%0d expected 55 2", bus.out_data, bus.words_sent);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive(1'b0, 1'b0, 32'h66, 1'b0);
    drive(1'b0, 1'b0, 32'h77, 1'b1);
    drive(1'b1, 1'b0, 32'h99, 1'b1);
    checks++;
    if (bus.fifo_pop !== 1'b0) begin
      errors++; $display("FAIL rstmid_pop: got %b expected 0", bus.fifo_pop);
    end
    drive(1'b0, 1'b0, 32'h88, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.words_sent !== '0 || bus.fifo_pop !== 1'b1) begin
      errors++; $display("FAIL rstmid_after: got valid=%b sent=%0d pop=%b expected 0 0 1", bus.out_valid, bus.words_sent, bus.fifo_pop);
    end
    drive(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h88) begin
      errors++; $display("FAIL rstmid_first: got valid=%b data=%h expected 1 88", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, (i >= 20), DW'(i), 1'b1);
      checks++;
      if (bus.words_sent !== exp_sent()) begin
        errors++; $display("FAIL sat_%0d: got %0d expected %0d", i, bus.words_sent, exp_sent());
      end
    end
    checks++;
    if (bus.words_sent !== CW'(SAT)) begin
      errors++; $display("FAIL sat_final: got %0d expected %0d", bus.words_sent, SAT);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 3) != 0));
      checks++;
      if (bus.fifo_pop !== exp_pop() || bus.out_valid !== (mq.size() > 0) ||
          bus.busy !== ((mq.size() > 0) || !bus.fifo_empty) || bus.words_sent !== exp_sent()) begin
        errors++; $display("FAIL rand_ctl_%0d: got pop=%b valid=%b busy=%b sent=%0d expected %b %b %b %0d",
                           i, bus.fifo_pop, bus.out_valid, bus.busy, bus.words_sent,
                           exp_pop(), (mq.size() > 0), ((mq.size() > 0) || !bus.fifo_empty), exp_sent());
      end
      if (mq.size() > 0) begin
        checks++;
        if (bus.out_data !== mq[0]) begin
          errors++; $display("FAIL rand_data_%0d: got %h expected %h", i, bus.out_data, mq[0]);
        end
      end
    end
  endtask

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter DATA_W, default 32, width of FIFO words and output data.
REQ-002 Parameter CNT_W, default 16, width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_data  input  DATA_W  upstream FIFO read data, valid in the cycle fifo_pop is high.
REQ-007 fifo_pop  output  1  single-cycle pop request to upstream FIFO.
REQ-008 out_valid  output  1  output word available.
REQ-009 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-010 out_data  output  DATA_W  output word, head of internal buffer.
REQ-011 words_sent  output  CNT_W  count of completed output handshakes.
REQ-012 busy  output  1  high while buffer nonempty or fifo_empty low.

Function
REQ-013 Block SHALL hold a 2-entry internal buffer with occupancy states EMPTY (0), ONE (1), FULL (2).
REQ-014 fifo_pop SHALL be combinational: high iff reset low, fifo_empty low, and state not FULL.
REQ-015 On each edge with fifo_pop high, fifo_data SHALL be written into the buffer tail (capture in the pop cycle; zero read latency).
REQ-016 Output handshake: word transfers on an edge with out_valid and out_ready both high; buffer head SHALL then advance.
REQ-017 out_valid SHALL equal (state != EMPTY); out_valid SHALL depend only on registered state, never on out_ready.
REQ-018 out_data SHALL be the buffer head and SHALL remain stable while out_valid high and out_ready low.
REQ-019 Transitions: push only -> occupancy +1; handshake only -> occupancy -1; push and handshake same edge -> occupancy unchanged, order preserved; neither -> unchanged.
REQ-020 In state FULL, fifo_pop SHALL be low even if out_ready is high in that cycle (no pop-through at full).
REQ-021 Words SHALL leave in exactly the order popped; no word dropped or duplicated.
REQ-022 Minimum latency: word popped at edge N SHALL appear on out_data with out_valid high in cycle N+1 when buffer was EMPTY.
REQ-023 Sustained throughput SHALL be one word per cycle when fifo_empty stays low and out_ready stays high.
REQ-024 words_sent SHALL increment by 1 per handshake and saturate at 2^CNT_W-1 (no wrap).
REQ-025 busy SHALL be combinational: (state != EMPTY) or (fifo_empty == 0).
REQ-026 fifo_empty toggling mid-stream SHALL only gate fifo_pop; buffered words SHALL still drain.

Reset
REQ-027 While reset high, fifo_pop SHALL be 0 and no buffer write or handshake count SHALL occur.
REQ-028 After a reset edge: state EMPTY, out_valid 0, out_data 0, words_sent 0, buffer contents 0.
REQ-029 Reset mid-operation SHALL discard buffered words; first cycle after reset deasserts SHALL behave as from power-up.

Verification
REQ-030 Single word: fifo_empty low one cycle, fifo_data=0xA5A5_0001, out_ready high -> fifo_pop high 1 cycle, next cycle out_valid=1, out_data=0xA5A5_0001, words_sent=1 after handshake.
REQ-031 Backpressure: 3 words 0x11,0x22,0x33 available, out_ready low -> exactly 2 pops, state FULL, fifo_pop 0, out_data holds 0x11; raise out_ready -> 0x11,0x22,0x33 in order, third pop only after first handshake.
REQ-032 Streaming: fifo_empty low 8 cycles with words 1..8, out_ready high -> 8 consecutive handshakes, one per cycle, words_sent=8.
REQ-033 Simultaneous: state ONE, push 0x44 and handshake same edge -> state stays ONE, out_data becomes 0x44.
REQ-034 Reset mid-stream: state FULL, assert reset 1 cycle -> out_valid 0, words_sent 0, fifo_pop 0 during reset, buffered words never appear.
REQ-035 Saturation: CNT_W=4, 20 handshakes -> words_sent stops at 15.
